if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Parametrised IF->ID pipeline buffer that replaces the single-entry IF/ID register.
//  Holds up to DEPTH fetched {inst, addr} pairs in a circular queue with valid/ready
//  handshakes on both sides. Supports decode-side hold and pipeline flush.
//  Drives a NOP bubble to decode whenever the queue is empty.
// PARAMETERS
//  XLEN      32            instruction and address width
//  DEPTH     2             queue entries; power of two, >= 2
//  NOP_INST  32'h00000013  instruction driven when empty (addi x0,x0,0)
//  CNT_W     $clog2(DEPTH+1)  occupancy width (derived, do not override)
// PORTS
//  clk        in   1      clock, rising edge
//  rstn       in   1      reset, asynchronous, active-low
//  flush_i    in   1      discard all entries (branch/jump/trap redirect)
//  hold_i     in   1      decode stall; blocks pop only
//  in_valid   in   1      IF presents inst_i/addr_i
//  in_ready   out  1      queue can accept (= !full)
//  inst_i     in   XLEN   fetched instruction
//  addr_i     in   XLEN   fetch PC
//  out_valid  out  1      head entry valid (= !empty)
//  out_ready  in   1      ID consumes head
//  inst_o     out  XLEN   head instruction, NOP_INST when empty
//  addr_o     out  XLEN   head PC, 0 when empty
//  count_o    out  CNT_W  current occupancy
// BEHAVIOUR
//  - Reset (rstn=0, async): wr_ptr=rd_ptr=0, count=0; in_ready=1, out_valid=0,
//    inst_o=NOP_INST, addr_o=0, count_o=0. Storage array is not reset.
//  - push = in_valid & in_ready & !flush_i; pop = out_valid & out_ready & !hold_i & !flush_i.
//  - in_ready depends on registered count only; no combinational path from out_ready.
//    When full, a pop frees the slot the NEXT cycle (no same-cycle pass-through).
//  - push & pop same cycle (not full, not empty): count unchanged, both pointers advance.
//  - Latency: entry pushed in cycle N is visible at outputs in cycle N+1.
//  - Outputs are the head entry, combinationally muxed from storage[rd_ptr], forced to
//    NOP_INST / 0 when count==0.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count disambiguates full/empty.
//  - flush_i (synchronous): next cycle count=0, pointers=0; push and pop in the flush cycle
//    are ignored. Flush takes priority over hold, push and pop.
//  - hold_i: head and count frozen w.r.t. pop; pushes still accepted while not full.
//  - Order strictly FIFO; no entry is ever duplicated or dropped except by flush/reset.
//  - Assertions: no push when count==DEPTH, no pop when count==0, count <= DEPTH.
// STRUCTURE
//  - NOP_INST, ZeroWord and the hold/flush encodings come from the shared defines file;
//    the top-level core maps hold bus -> hold_i and flush bus bit for IF/ID -> flush_i.
//  - One sub-module: if_id_queue_ctrl (pointers, count, full/empty, push/pop qualify).
//    Storage array and output mux stay in if_id_queue.
// TESTING
//  1 Reset: rstn=0 mid-run with count=2 -> same cycle out_valid=0, inst_o=32'h13,
//    addr_o=0, count_o=0, in_ready=1.
//  2 Fill: DEPTH=2, push 0x111/0x100, 0x222/0x104, out_ready=0 -> count_o=2, in_ready=0,
//    third in_valid ignored; inst_o=0x111, addr_o=0x100.
//  3 Stream: in_valid=out_ready=1 for 8 cycles, inst=k -> count_o steady at 1, outputs
//    inst 0..7 in order, one per cycle after 1-cycle latency.
//  4 Hold: count=1, hold_i=1, out_ready=1, push 0x333 -> count_o=2, head unchanged;
//    release hold -> 0x111 then 0x333 emitted.
//  5 Flush: count=2 with simultaneous push and pop, flush_i=1 -> next cycle count_o=0,
//    inst_o=32'h13, pushed entry absent.
//  6 Wrap: DEPTH=4, 10 push/pop mixes crossing pointer wrap twice -> scoreboard order
//    exact, full/empty flags match reference model every cycle.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants and helpers for the IF->ID instruction queue.
package if_id_queue_pkg;

  localparam int XLEN_DEF = 32;

  // addi x0,x0,0 -- the bubble decode sees whenever the queue is empty
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Per-cycle queue operation, encoded as {pop, push}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } queueOp_e;

  function automatic queueOp_e decodeOp(input logic push, input logic pop);
    return queueOp_e'({pop, push});
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch, the IF/ID queue and decode.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) ();

  logic             flush_i;
  logic             hold_i;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  inst_i;
  logic [XLEN-1:0]  addr_i;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  inst_o;
  logic [XLEN-1:0]  addr_o;
  logic [CNT_W-1:0] count_o;

  // Pipeline side: drives fetch data and decode control, observes the head
  modport master (
    output flush_i, hold_i, in_valid, inst_i, addr_i, out_ready,
    input  in_ready, out_valid, inst_o, addr_o, count_o
  );

  // Queue side
  modport slave (
    input  flush_i, hold_i, in_valid, inst_i, addr_i, out_ready,
    output in_ready, out_valid, inst_o, addr_o, count_o
  );

endinterface

// File: rtl/if_id_queue_ctrl.sv
// Pointer/occupancy bookkeeping for the IF/ID queue: qualifies push/pop,
// tracks write/read pointers and count, handles flush.
module if_id_queue_ctrl
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             inValid_i,
  input  logic             outReady_i,
  output logic             push_o,
  output logic             pop_o,
  output logic [PTR_W-1:0] wrPtr_o,
  output logic [PTR_W-1:0] rdPtr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             inReady_o,
  output logic             outValid_o
);

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             empty;
  queueOp_e         op;

  // Flags come from the registered count only, so in_ready never depends on out_ready
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    inReady_o  = !full;
    outValid_o = !empty;
    push_o     = inValid_i && !full && !flush_i;
    pop_o      = !empty && outReady_i && !hold_i && !flush_i;
    wrPtr_o    = wrPtr_q;
    rdPtr_o    = rdPtr_q;
    count_o    = count_q;
  end

  // Next-state: flush clears everything, otherwise pointers wrap modulo DEPTH
  always_comb begin
    op      = decodeOp(push_o, pop_o);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_o) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop_o) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case (op)
        OP_PUSH: count_d = count_q + CNT_W'(1);
        OP_POP:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Occupancy invariants
  assert property (@(posedge clk) disable iff (!rstn) !(push_o && full));
  assert property (@(posedge clk) disable iff (!rstn) !(pop_o && empty));
  assert property (@(posedge clk) disable iff (!rstn) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/if_id_queue.sv
// IF->ID pipeline buffer: a DEPTH-entry circular queue of {inst, addr}
// pairs; decode sees a NOP bubble whenever the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
  input logic          clk,
  input logic          rstn,
  if_id_queue_if.slave q
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             inReady;
  logic             outValid;

  logic [XLEN-1:0]  instMem_q [DEPTH];
  logic [XLEN-1:0]  addrMem_q [DEPTH];

  if_id_queue_ctrl #(
    .DEPTH (DEPTH)
  ) uCtrl (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (q.flush_i),
    .hold_i     (q.hold_i),
    .inValid_i  (q.in_valid),
    .outReady_i (q.out_ready),
    .push_o     (push),
    .pop_o      (pop),
    .wrPtr_o    (wrPtr),
    .rdPtr_o    (rdPtr),
    .count_o    (count),
    .inReady_o  (inReady),
    .outValid_o (outValid)
  );

  // Storage is written only on an accepted push and is deliberately not reset
  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr] <= q.inst_i;
      addrMem_q[wrPtr] <= q.addr_i;
    end
  end

  // Head entry straight from storage, replaced by a NOP bubble when empty
  always_comb begin
    q.inst_o = NOP_INST;
    q.addr_o = XLEN'(ZERO_WORD);
    if (outValid) begin
      q.inst_o = instMem_q[rdPtr];
      q.addr_o = addrMem_q[rdPtr];
    end
  end

  assign q.in_ready  = inReady;
  assign q.out_valid = outValid;
  assign q.count_o   = count;

  // pop is consumed inside the controller; it is kept here for waveform visibility
  logic popSeen;
  assign popSeen = pop;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2 and DEPTH=4 instances).
module tb_if_id_queue;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  if_id_queue_if #(.XLEN(32), .DEPTH(2)) bus2 ();
  if_id_queue_if #(.XLEN(32), .DEPTH(4)) bus4 ();

  if_id_queue #(.XLEN(32), .DEPTH(2)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .q    (bus2.slave)
  );

  if_id_queue #(.XLEN(32), .DEPTH(4)) dut4 (
    .clk  (clk),
    .rstn (rstn),
    .q    (bus4.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [$];

  bit wrapIn  [17] = '{1,1,1,1,1,1,1,1,1,0,1,1,0,0,0,0,0};
  bit wrapOut [17] = '{0,0,0,0,0,1,1,1,1,1,0,0,1,1,1,1,1};

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one instance's inputs for the coming cycle
  task automatic applyStimulus(input int sel, input logic inV, input logic [31:0] inst,
                               input logic [31:0] addr, input logic outR,
                               input logic hold, input logic flush);
    if (sel == 2) begin
      bus2.in_valid  = inV;
      bus2.inst_i    = inst;
      bus2.addr_i    = addr;
      bus2.out_ready = outR;
      bus2.hold_i    = hold;
      bus2.flush_i   = flush;
    end else begin
      bus4.in_valid  = inV;
      bus4.inst_i    = inst;
      bus4.addr_i    = addr;
      bus4.out_ready = outR;
      bus4.hold_i    = hold;
      bus4.flush_i   = flush;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every observable output of one instance
  task automatic checkState(input int sel, input string tag, input logic expValid,
                            input logic [31:0] expInst, input logic [31:0] expAddr,
                            input int expCount, input logic expReady);
    logic        v;
    logic        r;
    logic [31:0] i;
    logic [31:0] a;
    int          c;
    if (sel == 2) begin
      v = bus2.out_valid; r = bus2.in_ready; i = bus2.inst_o; a = bus2.addr_o;
      c = int'(bus2.count_o);
    end else begin
      v = bus4.out_valid; r = bus4.in_ready; i = bus4.inst_o; a = bus4.addr_o;
      c = int'(bus4.count_o);
    end
    checkOutput($sformatf("%s.out_valid", tag), 64'(v), 64'(expValid));
    checkOutput($sformatf("%s.in_ready", tag), 64'(r), 64'(expReady));
    checkOutput($sformatf("%s.inst_o", tag), 64'(i), 64'(expInst));
    checkOutput($sformatf("%s.addr_o", tag), 64'(a), 64'(expAddr));
    checkOutput($sformatf("%s.count_o", tag), 64'(c), 64'(expCount));
  endtask

  initial begin
    logic        doPush;
    logic        doPop;
    logic [31:0] wInst;
    logic [31:0] wAddr;
    logic [63:0] headVal;
    int          sz;

    applyStimulus(2, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(4, 0, 32'h0, 32'h0, 0, 0, 0);
    rstn = 1'b0;
    #12;
    checkState(2, "reset2", 0, 32'h13, 32'h0, 0, 1);
    checkState(4, "reset4", 0, 32'h13, 32'h0, 0, 1);
    rstn = 1'b1;
    tick();

    // Fill DEPTH=2 with decode stalled; a third offer must be refused
    applyStimulus(2, 1, 32'h111, 32'h100, 0, 0, 0);
    tick();
    checkState(2, "fill1", 1, 32'h111, 32'h100, 1, 1);
    applyStimulus(2, 1, 32'h222, 32'h104, 0, 0, 0);
    tick();
    checkState(2, "fill2", 1, 32'h111, 32'h100, 2, 0);
    applyStimulus(2, 1, 32'h999, 32'h1fc, 0, 0, 0);
    tick();
    checkState(2, "fill3", 1, 32'h111, 32'h100, 2, 0);

    // Asynchronous reset while full takes effect without a clock edge
    #1 rstn = 1'b0;
    #1;
    checkState(2, "midReset", 0, 32'h13, 32'h0, 0, 1);
    applyStimulus(2, 0, 32'h0, 32'h0, 0, 0, 0);
    #1 rstn = 1'b1;
    tick();

    // Streaming: one in, one out per cycle after one cycle of latency
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2, 1, 32'(k), 32'(k * 4), 1, 0, 0);
      tick();
      checkState(2, $sformatf("stream%0d", k), 1, 32'(k), 32'(k * 4), 1, 1);
    end
    applyStimulus(2, 0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    checkState(2, "streamDrain", 0, 32'h13, 32'h0, 0, 1);

    // Hold blocks pop but not push
    applyStimulus(2, 1, 32'h111, 32'h100, 0, 0, 0);
    tick();
    checkState(2, "hold0", 1, 32'h111, 32'h100, 1, 1);
    applyStimulus(2, 1, 32'h333, 32'h108, 1, 1, 0);
    tick();
    checkState(2, "hold1", 1, 32'h111, 32'h100, 2, 0);
    applyStimulus(2, 0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    checkState(2, "hold2", 1, 32'h333, 32'h108, 1, 1);
    tick();
    checkState(2, "hold3", 0, 32'h13, 32'h0, 0, 1);

    // Flush beats simultaneous push, pop and hold (DEPTH=4 so the push is legal)
    applyStimulus(4, 1, 32'haaa, 32'h200, 0, 0, 0);
    tick();
    applyStimulus(4, 1, 32'hbbb, 32'h204, 0, 0, 0);
    tick();
    checkState(4, "flush0", 1, 32'haaa, 32'h200, 2, 1);
    applyStimulus(4, 1, 32'hccc, 32'h208, 1, 1, 1);
    tick();
    checkState(4, "flush1", 0, 32'h13, 32'h0, 0, 1);
    applyStimulus(4, 1, 32'hddd, 32'h20c, 0, 0, 0);
    tick();
    checkState(4, "flush2", 1, 32'hddd, 32'h20c, 1, 1);
    applyStimulus(4, 0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    checkState(4, "flush3", 0, 32'h13, 32'h0, 0, 1);

    // Push/pop mix on DEPTH=4 against a FIFO scoreboard; pointers wrap twice
    model.delete();
    for (int s = 0; s < 17; s++) begin
      wInst  = 32'(32'h5000 + s);
      wAddr  = 32'(s * 4);
      sz     = model.size();
      doPush = wrapIn[s] && (sz < 4);
      doPop  = wrapOut[s] && (sz > 0);
      applyStimulus(4, wrapIn[s], wInst, wAddr, wrapOut[s], 0, 0);
      tick();
      if (doPop) begin
        void'(model.pop_front());
      end
      if (doPush) begin
        model.push_back({wInst, wAddr});
      end
      sz = model.size();
      if (sz > 0) begin
        headVal = model[0];
        checkState(4, $sformatf("wrap%0d", s), 1, headVal[63:32], headVal[31:0], sz, sz < 4);
      end else begin
        checkState(4, $sformatf("wrap%0d", s), 0, 32'h13, 32'h0, 0, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
